// File: rtl/ifetch_unit_pkg.sv
// ifetch_unit_pkg: shared constants, fetch state encoding and fetch-entry type for the fetch unit.
package ifetch_unit_pkg;

    localparam logic [31:0] NOP                    = 32'h00000013;
    localparam logic [3:0]  EXC_INSTR_MISALIGNED   = 4'd0;
    localparam logic [3:0]  EXC_INSTR_ACCESS_FAULT = 4'd1;

    typedef enum logic {
        RUN,
        FAULT
    } fetch_state_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        exc_en;
        logic [3:0]  exc_code;
        logic [63:0] exc_val;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_queue.sv
// ifetch_queue: circular FIFO of fetch entries with flush and push-while-full-on-pop.
// Ports: clk, rst (sync, active-low), i_flush (drop all entries), i_push/i_push_entry,
//        i_pop, o_head (zero while empty), o_count (0..DEPTH), o_full.
module ifetch_queue
    import ifetch_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  fetch_entry_t               i_push_entry,
    input  logic                       i_pop,
    output fetch_entry_t               o_head,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_wr;
    logic [AW:0]   r_count;
    logic          w_pop;
    logic          w_push;

    assign o_full  = r_count == (AW+1)'(DEPTH);
    assign w_pop   = i_pop && r_count != '0;
    // A pop frees the head slot in the same edge, so a full queue can still accept.
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_head  = r_count == '0 ? '0 : r_mem[r_rd];
    assign o_count = r_count;

    always_ff @(posedge clk) begin
        if (!rst || i_flush) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= i_push_entry;
                r_wr        <= r_wr + AW'(1);
            end
            if (w_pop)
                r_rd <= r_rd + AW'(1);
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch initiator owning the PC, queuing fetch results for decode.
// Ports: clk, rst (sync, active-low); redirect_en/redirect_pc; pc_addr to memory with
//        instruction/exc_en/exc_code/exc_val returned in the same cycle; decode handshake
//        out_valid/out_ready with head fields out_pc/out_instr/out_exc_en/out_exc_code/out_exc_val;
//        fetch_cnt delivered-instruction counter.
// Build option: define IFU_FETCH_CNT_EN to implement fetch_cnt; otherwise it reads zero.
module ifetch_unit
    import ifetch_unit_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_en,
    input  logic [63:0] redirect_pc,
    output logic [63:0] pc_addr,
    input  logic [31:0] instruction,
    input  logic        exc_en,
    input  logic [3:0]  exc_code,
    input  logic [63:0] exc_val,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_pc,
    output logic [31:0] out_instr,
    output logic        out_exc_en,
    output logic [3:0]  out_exc_code,
    output logic [63:0] out_exc_val,
    output logic [63:0] fetch_cnt
);

    fetch_state_t            r_state;
    fetch_state_t            w_state_nxt;
    logic [63:0]             r_pc;
    logic [63:0]             w_pc_nxt;
    fetch_entry_t            w_push_entry;
    fetch_entry_t            w_head;
    logic [$clog2(QDEPTH):0] w_count;
    logic                    w_full;
    logic                    w_pop;
    logic                    w_push;
    logic                    w_misal;
    logic                    w_fault;

    assign pc_addr   = r_pc;
    assign out_valid = w_count != '0;
    assign w_pop     = out_valid && out_ready;
    assign w_misal   = |r_pc[1:0];
    // Misalignment is detected locally and overrides whatever the memory returns.
    assign w_fault   = w_misal || exc_en;
    assign w_push    = r_state == RUN && !redirect_en && (!w_full || w_pop);

    always_comb begin
        w_push_entry          = '0;
        w_push_entry.pc       = r_pc;
        w_push_entry.instr    = w_fault ? NOP : instruction;
        w_push_entry.exc_en   = w_fault;
        w_push_entry.exc_code = w_misal ? EXC_INSTR_MISALIGNED : (exc_en ? exc_code : 4'd0);
        w_push_entry.exc_val  = w_misal ? r_pc : (exc_en ? exc_val : 64'd0);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        if (redirect_en) begin
            w_state_nxt = RUN;
            w_pc_nxt    = redirect_pc;
        end else if (w_push) begin
            w_state_nxt = w_fault ? FAULT : RUN;
            w_pc_nxt    = w_fault ? r_pc : r_pc + 64'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= RUN;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    ifetch_queue #(
        .DEPTH(QDEPTH)
    ) u_queue (
        .clk          (clk),
        .rst          (rst),
        .i_flush      (redirect_en),
        .i_push       (w_push),
        .i_push_entry (w_push_entry),
        .i_pop        (w_pop),
        .o_head       (w_head),
        .o_count      (w_count),
        .o_full       (w_full)
    );

    assign out_pc       = w_head.pc;
    assign out_instr    = w_head.instr;
    assign out_exc_en   = w_head.exc_en;
    assign out_exc_code = w_head.exc_code;
    assign out_exc_val  = w_head.exc_val;

`ifdef IFU_FETCH_CNT_EN
    logic [63:0] r_fetch_cnt;

    always_ff @(posedge clk) begin
        if (!rst)
            r_fetch_cnt <= '0;
        else if (w_pop && !w_head.exc_en)
            r_fetch_cnt <= r_fetch_cnt + 64'd1;
    end

    assign fetch_cnt = r_fetch_cnt;
`else
    assign fetch_cnt = 64'h0;
`endif

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
Instruction fetch initiator that drives the instruction-memory read port. It owns the PC and samples instruction and fault responses from the combinational memory in the same cycle. Results are buffered in a small fetch queue and handed to decode over a valid/ready handshake. Redirects from branches and traps flush the queue and restart fetch.

Parameters:
RESET_PC, 64'h0000_0000_0000_0000, PC loaded on reset.
QDEPTH, 2, fetch queue entries; power of 2, legal range 2..8.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous reset, active-low (rst=0 resets on clk edge)
redirect_en  input  1  branch/trap redirect strobe
redirect_pc  input  64  new fetch PC when redirect_en=1
pc_addr  output  64  fetch address to instruction memory (registered PC)
instruction  input  32  memory read data for pc_addr, same cycle
exc_en  input  1  memory reports instruction access fault for pc_addr
exc_code  input  4  memory fault cause
exc_val  input  64  memory fault value (bad PC)
out_valid  output  1  queue head valid
out_ready  input  1  decode accepts head
out_pc  output  64  PC of head entry
out_instr  output  32  instruction of head entry (32'h00000013 on fault entries)
out_exc_en  output  1  head entry carries a fetch exception
out_exc_code  output  4  head exception cause
out_exc_val  output  64  head exception value
fetch_cnt  output  64  delivered-instruction counter (see Optional Feature)

Behaviour:
- Reset (rst=0 at edge, any state, mid-operation included): pc=RESET_PC, queue count=0, state=RUN, fetch_cnt=0. out_valid=0. Head fields read 0 while empty.
- pc_addr is the PC register. The memory responds combinationally, so an entry is pushed at the edge that ends the cycle, and it appears at the head 1 cycle later when the queue was empty.
- States: RUN (fetching), FAULT (fetch halted after an exception entry, waiting for redirect).
- Priority each edge: rst > redirect_en > pop/push.
- redirect_en=1: count=0 (all entries dropped, including any popped this cycle), pc=redirect_pc, state=RUN, no push this cycle. A redirect in FAULT is the only exit from FAULT.
- Push conditions: state=RUN, no redirect, and (count<QDEPTH or a pop occurs this cycle). Full with a simultaneous pop pushes, so count stays QDEPTH.
- Push classification, in order:
  1. pc[1:0]!=0: exception entry, code 4'd0 (misaligned), val=pc, instr=NOP. State goes to FAULT, pc held. The memory response is ignored.
  2. exc_en=1: exception entry with the memory's exc_code/exc_val, instr=NOP. State goes to FAULT, pc held.
  3. Otherwise: normal entry {pc, instruction}, pc=pc+4 (mod 2^64, wraps to 0).
- FAULT: no push, pc held and still driven on pc_addr. The memory's toggling exc_en is ignored. Queued entries continue to drain.
- Pop: out_valid & out_ready. Entries never reorder or duplicate.
- No push when the queue is full and there is no pop. pc is held, and the same address is re-presented next cycle.
- Queue is a circular buffer with wrapping read/write pointers plus a count (0..QDEPTH).

Optional Feature:
IFU_FETCH_CNT_EN.
- Defined: fetch_cnt increments by 1 on every pop with out_exc_en=0, wraps mod 2^64, and is cleared by reset only (not by redirect).
- Undefined: fetch_cnt is tied to 64'h0, with no counter flops.

Decomposition:
- Shared package: NOP constant 32'h00000013, exception cause constants (EXC_INSTR_MISALIGNED=4'd0, EXC_INSTR_ACCESS_FAULT=4'd1), fetch state encoding (RUN, FAULT), and the fetch-entry packed struct {pc, instr, exc_en, exc_code, exc_val}.
- One sub-module: ifetch_queue. It is a parametric synchronous FIFO of fetch entries with push/pop/flush, count, full/empty, and simultaneous push+pop when full.

Test Plan:
- Reset with RESET_PC=0, memory holds 0x00500093 at word 0, out_ready=1 -> pc_addr=0 after reset; out_valid=1 next cycle with out_pc=0, out_instr=0x00500093; pc_addr=4.
- out_ready=0 for 5 cycles, QDEPTH=2 -> count saturates at 2 and pc_addr holds 8. With out_ready=1, entries for PC 0 and 4 are delivered in order, then PC 8.
- Advance pc to 0x20000 (out of range) -> one exception entry, code 1, val 0x20000, instr 0x13; state FAULT, pc_addr held, no further pushes despite memory exc_en toggling.
- In FAULT, redirect_en=1 with redirect_pc=0x40 -> queue empty next cycle; pc_addr=0x40; normal fetch resumes.
- redirect_pc=0x42 -> exception entry with code 0, val 0x42; FAULT.
- redirect while full with simultaneous pop -> count 0, the popped entry is not redelivered. With IFU_FETCH_CNT_EN defined, 10 normal pops plus 1 fault pop -> fetch_cnt=10; undefined -> fetch_cnt=0.
